// File: rtl/calc_pkg.sv
// Shared types and constants for the 3-bit calculator: entry FSM states,
// operation codes and operand width.
package calc_pkg;

    localparam int W_OPERANDO = 3;

    localparam logic [1:0] OP_SOMA = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {
        ESPERA_A  = 2'd0,
        ESPERA_B  = 2'd1,
        ESPERA_OP = 2'd2,
        PRONTO    = 2'd3
    } estado_t;

endpackage

// File: rtl/debounce_botao.sv
// Pushbutton conditioning: two-flop synchronizer, counter debouncer and a
// one-cycle pulse on each debounced rising edge.
module debounce_botao #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          db_d;
    logic          dbPrev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The level only flips after DEB_CYCLES consecutive disagreeing samples;
    // any agreement in between restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                db_d  = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            dbPrev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn;
            s2_q     <= s1_q;
            db_q     <= db_d;
            dbPrev_q <= db_q;
            cnt_q    <= cnt_d;
        end
    end

    assign press = db_q & ~dbPrev_q;

endmodule

// File: rtl/entrada_calculadora.sv
// Operand-entry stage: walks the user through A, B and the operation with a
// single button and presents registered operands plus valid/div-by-zero flags.
module entrada_calculadora
    import calc_pkg::*;
#(
    parameter int W          = W_OPERANDO,
    parameter int DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn,
    input  logic [W-1:0] sw,
    input  logic [1:0]   sw_sel,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [1:0]   sel,
    output logic         valid,
    output logic         erro_div0,
    output logic [1:0]   estado
);

    logic         press;
    estado_t      estado_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [1:0]   sel_q;
    logic         valid_q;
    logic         erro_q;

    debounce_botao #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    // Switches are only looked at in the press cycle; operands persist
    // across the return to ESPERA_A until the next entry overwrites them.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= ESPERA_A;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= OP_SOMA;
            valid_q  <= 1'b0;
            erro_q   <= 1'b0;
        end else if (press) begin
            case (estado_q)
                ESPERA_A: begin
                    a_q      <= sw;
                    estado_q <= ESPERA_B;
                end
                ESPERA_B: begin
                    b_q      <= sw;
                    estado_q <= ESPERA_OP;
                end
                ESPERA_OP: begin
                    sel_q    <= sw_sel;
                    valid_q  <= 1'b1;
                    erro_q   <= (sw_sel == OP_DIV) && (b_q == '0);
                    estado_q <= PRONTO;
                end
                PRONTO: begin
                    valid_q  <= 1'b0;
                    erro_q   <= 1'b0;
                    estado_q <= ESPERA_A;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign sel       = sel_q;
    assign valid     = valid_q;
    assign erro_div0 = erro_q;
    assign estado    = estado_q;

endmodule

// File: doc/entrada_calculadora.md
Name: entrada_calculadora

Overview:
- Upstream operand-entry stage for the 3-bit calculator datapath and its 7-segment display decoder.
- Takes raw slide switches and one raw pushbutton from the board. Sequences the user through entering A, then B, then the operation.
- Presents stable registered A, B and sel to the calculator, plus a valid flag and a divide-by-zero error flag.
- Contains the button synchronizer, debouncer and press-edge detector.

Parameters:
- W, 3, operand width; drives A, B and sw.
- DEB_CYCLES, 4, consecutive stable cycles required before the debounced level changes. Use 4 in simulation, about 500000 on the board. Minimum 2.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- btn  in  1  raw pushbutton, asynchronous and bouncy; 1 = pressed.
- sw  in  W  operand switches.
- sw_sel  in  2  operation switches: 00 add, 01 sub, 10 mul, 11 div.
- A  out  W  registered operand A to the calculator.
- B  out  W  registered operand B to the calculator.
- sel  out  2  registered operation select to the calculator.
- valid  out  1  high while A, B and sel form a complete, confirmed operation.
- erro_div0  out  1  high with valid when sel=11 and B=0.
- estado  out  2  current FSM state, for status LEDs.

Behaviour:
- Reset (sync, active-high):
  - A=0, B=0, sel=00, valid=0, erro_div0=0, estado=ESPERA_A.
  - Synchronizer flops, debounced level and debounce counter all cleared.
- Reset mid-entry: discards partial entry and returns to ESPERA_A.
  - A button held through reset is treated as a new press once debounced.
- Synchronizer: two flops, btn -> s1 -> s2.
- Debouncer:
  - cnt increments each cycle s2 != db, and clears when s2 == db.
  - When s2 != db and cnt == DEB_CYCLES-1: db <= s2 and cnt <= 0.
  - Pulses shorter than DEB_CYCLES cycles (after sync) are ignored.
- Press event: press = db & ~db_q, exactly one cycle per debounced rising edge. Release is not an event.
- Latency: let edge 0 be the first edge sampling btn=1, with btn held stable.
  - db rises at edge DEB_CYCLES+1.
  - FSM and output registers update at edge DEB_CYCLES+2.
- FSM (estado encoding: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, PRONTO=3):
  - ESPERA_A + press: A <= sw, go ESPERA_B.
  - ESPERA_B + press: B <= sw, go ESPERA_OP.
  - ESPERA_OP + press: sel <= sw_sel, valid <= 1, erro_div0 <= (sw_sel==11 && B==0), go PRONTO.
  - PRONTO + press: valid <= 0, erro_div0 <= 0, go ESPERA_A. A, B and sel hold their last values until overwritten.
  - No press: state and all outputs hold.
- Switch sampling:
  - Switch changes without a press have no effect.
  - Switches are sampled in the press cycle only. They are treated as quasi-static and are not synchronized.
- valid and erro_div0 are registered. erro_div0 is never high while valid is low.

Decomposition:
- Package calc_pkg holds:
  - typedef enum logic [1:0] estado_t {ESPERA_A, ESPERA_B, ESPERA_OP, PRONTO};
  - op constants OP_SOMA=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - W_OPERANDO=3.
- The calculator and display stages import the same op constants.
- One sub-module, debounce_botao: synchronizer + debouncer + edge detect.
  - Ports: clk, rst, btn, press. Parameter DEB_CYCLES.
- The FSM and operand registers live in the top module.

Test Plan (all with DEB_CYCLES=4):
- Reset check: rst high 2 cycles -> all outputs 0, estado=0. Then btn held high from reset release -> no press before 6 edges; press at edge 6.
- Full sequence:
  - sw=6, press -> A=6, estado=1.
  - sw=7, press -> B=7, estado=2.
  - sw_sel=10, press -> sel=10, valid=1, erro_div0=0, estado=3.
  - Calculator result = 42.
- Bounce rejection: btn toggling 1,0,1,0 at 1-cycle intervals, then 0 -> no press, estado unchanged. One bounce then stable 1 -> exactly one press, at edge DEB_CYCLES+2 after the last 0->1 change.
- Divide by zero: A=5, B=0, sw_sel=11 -> valid=1, erro_div0=1. Next press -> valid=0, erro_div0=0, estado=0, A=5 and B=0 held.
- Long hold and switch churn: btn held 50 cycles -> single press. sw changes 0..7 during the hold -> A captures only the value present in the press cycle.
- Reset mid-entry: in ESPERA_OP, rst for 1 cycle -> estado=0, A=B=0, valid=0. The next sequence works normally.
